// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the async-FIFO read-side stream adapter.
// Covers the FSM encoding and the supported FIFO read latencies.
package fifo_rd_stream_pkg;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_FLUSH = 1'b1;

   localparam int RD_LAT_FWFT = 0;
   localparam int RD_LAT_REG  = 1;

   function automatic bit rd_lat_legal(input int lat);
      return (lat == RD_LAT_FWFT) || (lat == RD_LAT_REG);
   endfunction

endpackage

// File: rtl/fifo_rd_stream_skid_buf2.sv
// Two-entry FIFO-order register buffer; e0 is always the head entry.
// The caller never pushes into a full buffer or pops an empty one.
module skid_buf2 #(
   parameter int W = 8
) (
   input  logic         clk_RD,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   occ
);

   logic [W-1:0] e0, e1;

   always_ff @(posedge clk_RD) begin
      if (!rst_n) begin
         occ <= 2'd0;
         e0  <= '0;
         e1  <= '0;
      end else if (clr) begin
         occ <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) e0 <= din;
               else             e1 <= din;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               e0  <= e1;
               occ <= occ - 2'd1;
            end
            2'b11: begin
               // occupancy unchanged; new word goes behind whatever remains
               if (occ == 2'd1) e0 <= din;
               else begin
                  e0 <= e1;
                  e1 <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout = e0;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer for the async FIFO: credit-limited read strobe,
// 2-entry skid buffer to a valid/ready stream, and an in-band flush.
module fifo_rd_stream
   import fifo_rd_stream_pkg::*;
#(
   parameter int data_width = 8,
   parameter int RD_LAT     = 0,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_RD,
   input  logic                  rst_n,
   input  logic                  empty,
   input  logic [data_width-1:0] Q,
   output logic                  RD,
   input  logic                  flush,
   output logic [data_width-1:0] o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  flushing,
   output logic [CNT_WIDTH-1:0]  word_cnt
);

   localparam bit LAT_REG = rd_lat_legal(RD_LAT) && (RD_LAT == RD_LAT_REG);

   logic [0:0] state;
   logic       live;
   logic       inflight;
   logic [1:0] occ;
   logic [2:0] used;
   logic       in_flush, credit, cap, push, pop, clr;

   assign in_flush = (state == ST_FLUSH);
   assign used     = {1'b0, occ} + {2'b00, inflight};
   assign credit   = (used < 3'd2);
   // live holds RD low through reset and for the first cycle after release
   assign RD       = live && !empty && (in_flush || credit);
   assign cap      = LAT_REG ? inflight : RD;
   assign clr      = !in_flush && flush;
   assign push     = cap && !in_flush;
   assign o_valid  = (occ != 2'd0);
   assign pop      = o_valid && i_ready;
   assign flushing = in_flush;

   skid_buf2 #(.W(data_width)) u_skid (
      .clk_RD (clk_RD),
      .rst_n  (rst_n),
      .clr    (clr),
      .push   (push),
      .pop    (pop),
      .din    (Q),
      .dout   (o_data),
      .occ    (occ)
   );

   always_ff @(posedge clk_RD) begin
      if (!rst_n) begin
         state    <= ST_RUN;
         live     <= 1'b0;
         inflight <= 1'b0;
         word_cnt <= '0;
      end else begin
         live     <= 1'b1;
         inflight <= LAT_REG && RD;
         if (state == ST_RUN) begin
            if (flush) state <= ST_FLUSH;
         end else if (empty && !inflight) begin
            state <= ST_RUN;
         end
         if (clr)      word_cnt <= '0;
         else if (pop) word_cnt <= word_cnt + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench: lane 0 is FWFT with a 16-bit counter, lane 1 is RD_LAT=1 with a
// 4-bit counter; both share stimulus and are checked against a queue model.
module tb_fifo_rd_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, flush, i_ready, gate;
   logic [1:0]       emp, rd, ov, fl;
   logic [1:0][7:0]  q, od;
   logic [1:0][15:0] wc;

   int errs = 0, checks = 0, cyc = 0;

   for (genvar g = 0; g < 2; g++) begin : ln
      localparam int CW = (g == 0) ? 16 : 4;
      logic [CW-1:0] wcl;
      fifo_rd_stream #(.data_width(8), .RD_LAT(g), .CNT_WIDTH(CW)) u_dut (
         .clk_RD(clk), .rst_n(rst_n), .empty(emp[g]), .Q(q[g]), .RD(rd[g]),
         .flush(flush), .o_data(od[g]), .o_valid(ov[g]), .i_ready(i_ready),
         .flushing(fl[g]), .word_cnt(wcl));
      assign wc[g] = 16'(wcl);
   end

   // environment FIFO per lane
   logic [7:0] fmem[2][256];
   int         fhd[2], ftl[2];
   logic [7:0] qreg[2];
   // reference model per lane
   logic [7:0] mb[2][4];
   int         mocc[2], mcnt[2];
   bit         minf[2], mfl[2], mlive[2];
   // accepted words, hold tracking, last samples
   logic [7:0] got[2][128];
   int         ng[2];
   bit         phold[2];
   logic [7:0] pdat[2];
   logic       s_rd[2], s_ov[2], s_fl[2];
   logic [15:0] s_wc[2];
   int         first0 = -1, last0 = -1;

   task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s lane%0d: got %0h expected %0h at %0t", nm, g, act, exp, $time);
      end
   endtask

   task automatic load(input int base, input int n);
      for (int g = 0; g < 2; g++)
         for (int i = 0; i < n; i++) begin
            fmem[g][ftl[g] % 256] = 8'(base + i);
            ftl[g]++;
         end
   endtask

   task automatic step();
      bit         erd, acc, cap, ninf;
      logic [7:0] capd;
      logic       rd_act[2];
      for (int g = 0; g < 2; g++) begin
         emp[g] = gate || (ftl[g] == fhd[g]);
         q[g]   = (g == 1) ? qreg[g] : ((ftl[g] != fhd[g]) ? fmem[g][fhd[g] % 256] : 8'h00);
      end
      @(negedge clk);
      cyc++;
      for (int g = 0; g < 2; g++) begin
         erd = mlive[g] && !emp[g] && (mfl[g] || (mocc[g] + int'(minf[g]) < 2));
         chk("rd", g, 32'(rd[g]), 32'(erd));
         chk("rd_when_empty", g, 32'(rd[g] & emp[g]), 32'd0);
         chk("o_valid", g, 32'(ov[g]), 32'(mocc[g] > 0));
         if (mocc[g] > 0) chk("o_data", g, 32'(od[g]), 32'(mb[g][0]));
         chk("flushing", g, 32'(fl[g]), 32'(mfl[g]));
         chk("word_cnt", g, 32'(wc[g]), 32'(mcnt[g] & ((g == 0) ? 32'hFFFF : 32'hF)));
         if (phold[g]) begin
            chk("hold_valid", g, 32'(ov[g]), 32'd1);
            chk("hold_data", g, 32'(od[g]), 32'(pdat[g]));
         end
         phold[g] = ov[g] && !i_ready && !flush && rst_n;
         pdat[g]  = od[g];
         s_rd[g] = rd[g]; s_ov[g] = ov[g]; s_fl[g] = fl[g]; s_wc[g] = wc[g];
         rd_act[g] = rd[g];
         if (ov[g] && i_ready && ng[g] < 128) begin
            got[g][ng[g]] = od[g];
            ng[g]++;
            if (g == 0) begin
               if (first0 < 0) first0 = cyc;
               last0 = cyc;
            end
         end
         // model next state
         acc  = (mocc[g] > 0) && i_ready;
         cap  = (g == 0) ? erd : minf[g];
         capd = q[g];
         ninf = (g == 1) && erd;
         if (!rst_n) begin
            mocc[g] = 0; mcnt[g] = 0; minf[g] = 0; mfl[g] = 0; mlive[g] = 0;
         end else begin
            mlive[g] = 1;
            if (mfl[g]) begin
               if (emp[g] && !minf[g]) mfl[g] = 0;
            end else if (flush) begin
               mocc[g] = 0; mcnt[g] = 0; mfl[g] = 1;
            end else begin
               if (acc) begin
                  for (int k = 0; k < 3; k++) mb[g][k] = mb[g][k+1];
                  mocc[g]--;
                  mcnt[g]++;
               end
               if (cap && mocc[g] < 4) begin
                  mb[g][mocc[g]] = capd;
                  mocc[g]++;
               end
            end
            minf[g] = ninf;
         end
      end
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++)
         if (rd_act[g] && !emp[g]) begin
            if (g == 1) qreg[g] = fmem[g][fhd[g] % 256];
            fhd[g]++;
         end
   endtask

   task automatic check_got(input string nm, input int start, input int base, input int n);
      for (int g = 0; g < 2; g++) begin
         chk({nm, "_count"}, g, 32'(ng[g]), 32'(start + n));
         for (int i = 0; i < n; i++)
            chk({nm, "_word"}, g, 32'(got[g][start + i]), 32'(base + i));
      end
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; i_ready = 1'b1; gate = 1'b0;
      for (int g = 0; g < 2; g++) begin
         fhd[g] = 0; ftl[g] = 0; qreg[g] = 8'h00; mocc[g] = 0; mcnt[g] = 0;
         minf[g] = 0; mfl[g] = 0; mlive[g] = 0; ng[g] = 0; phold[g] = 0;
         for (int k = 0; k < 4; k++) mb[g][k] = 8'h00;
      end

      // reset with FIFO non-empty
      load(8'h01, 16);
      repeat (3) begin
         step();
         for (int g = 0; g < 2; g++) begin
            chk("reset_rd", g, 32'(s_rd[g]), 32'd0);
            chk("reset_valid", g, 32'(s_ov[g]), 32'd0);
            chk("reset_cnt", g, 32'(s_wc[g]), 32'd0);
            chk("reset_data", g, 32'(od[g]), 32'd0);
         end
      end
      rst_n = 1'b1;
      step();
      for (int g = 0; g < 2; g++) chk("rd_release_cycle", g, 32'(s_rd[g]), 32'd0);
      step();
      for (int g = 0; g < 2; g++) chk("first_rd", g, 32'(s_rd[g]), 32'd1);

      // streaming
      repeat (50) step();
      chk("stream_span", 0, 32'(last0 - first0), 32'd15);
      check_got("stream", 0, 8'h01, 16);
      chk("stream_cnt", 0, 32'(s_wc[0]), 32'd16);
      chk("stream_cnt", 1, 32'(s_wc[1]), 32'd0);

      // backpressure 1,0,0,1
      load(8'h21, 8);
      for (int k = 0; k < 48; k++) begin
         i_ready = (k % 4 == 0) || (k % 4 == 3);
         step();
      end
      i_ready = 1'b1;
      repeat (4) step();
      check_got("bp", 16, 8'h21, 8);
      chk("bp_cnt", 0, 32'(s_wc[0]), 32'd24);
      chk("bp_cnt", 1, 32'(s_wc[1]), 32'd8);

      // empty toggling every cycle
      load(8'h31, 6);
      repeat (30) begin
         gate = ~gate;
         step();
      end
      gate = 1'b0;
      repeat (4) step();
      check_got("toggle", 24, 8'h31, 6);
      chk("toggle_cnt", 0, 32'(s_wc[0]), 32'd30);
      chk("toggle_cnt", 1, 32'(s_wc[1]), 32'd14);

      // flush with words buffered, in flight and still in the FIFO
      i_ready = 1'b0;
      load(8'h41, 5);
      repeat (4) step();
      flush = 1'b1;
      step();
      step();
      for (int g = 0; g < 2; g++) begin
         chk("flush_valid", g, 32'(s_ov[g]), 32'd0);
         chk("flush_state", g, 32'(s_fl[g]), 32'd1);
      end
      flush = 1'b0;
      begin
         int n = 0;
         while ((s_fl[0] || s_fl[1]) && n < 20) begin
            step();
            n++;
         end
         chk("flush_exit_timeout", 0, 32'(s_fl[0] || s_fl[1]), 32'd0);
      end
      i_ready = 1'b1;
      repeat (5) step();
      for (int g = 0; g < 2; g++) begin
         chk("flush_fifo_drained", g, 32'(ftl[g] - fhd[g]), 32'd0);
         chk("flush_discard", g, 32'(ng[g]), 32'd30);
         chk("flush_cnt", g, 32'(s_wc[g]), 32'd0);
      end

      // counter wrap
      load(8'h51, 17);
      repeat (60) step();
      check_got("wrap", 30, 8'h51, 17);
      chk("wrap_cnt", 0, 32'(s_wc[0]), 32'd17);
      chk("wrap_cnt", 1, 32'(s_wc[1]), 32'd1);

      // reset beats a simultaneous flush
      load(8'h71, 3);
      i_ready = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      flush = 1'b1;
      step();
      rst_n = 1'b1;
      flush = 1'b0;
      step();
      for (int g = 0; g < 2; g++) begin
         chk("rst_flush_state", g, 32'(s_fl[g]), 32'd0);
         chk("rst_flush_valid", g, 32'(s_ov[g]), 32'd0);
         chk("rst_flush_cnt", g, 32'(s_wc[g]), 32'd0);
      end
      i_ready = 1'b1;
      repeat (20) step();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
